// File: rtl/alu_multiciclo_if.sv
// Issue/result bundle between the execute stage and the multi-cycle ALU.
interface alu_multiciclo_if #(
  parameter int WIDTH = 32
);
  logic             valid_in;
  logic             flush;
  logic [WIDTH-1:0] inputA;
  logic [WIDTH-1:0] inputB;
  logic [3:0]       alu_controle;
  logic [WIDTH-1:0] resultado;
  logic             valid_out;
  logic             busy;
  logic             stall;
  logic             zero;

  modport master (
    output valid_in, flush, inputA, inputB, alu_controle,
    input  resultado, valid_out, busy, stall, zero
  );

  modport slave (
    input  valid_in, flush, inputA, inputB, alu_controle,
    output resultado, valid_out, busy, stall, zero
  );
endinterface

// File: rtl/alu_multiciclo.sv
// Execute-stage ALU: single-cycle integer ops plus a bit-serial RV32M
// multiply/divide unit that holds the pipeline while it iterates.
module alu_multiciclo #(
  parameter int WIDTH = 32,
  parameter int CNT_W = $clog2(WIDTH) + 1
) (
  input logic              clk,
  input logic              reset,
  alu_multiciclo_if.slave  bus
);

  typedef enum logic [1:0] {IDLE, CALC, FIN} state_t;

  typedef enum logic [3:0] {
    OP_ADD  = 4'd0,  OP_SUB  = 4'd1,  OP_AND   = 4'd2,  OP_OR   = 4'd3,
    OP_XOR  = 4'd4,  OP_SLT  = 4'd5,  OP_SLTU  = 4'd6,  OP_MUL  = 4'd7,
    OP_MULH = 4'd8,  OP_MULHU = 4'd9, OP_DIV   = 4'd10, OP_DIVU = 4'd11,
    OP_REM  = 4'd12, OP_REMU = 4'd13
  } op_t;

  localparam logic [WIDTH-1:0] MOST_NEG = {1'b1, {(WIDTH-1){1'b0}}};

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt;
  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   opb;
  logic [3:0]         op_q;
  logic               neg_q;
  logic [WIDTH-1:0]   resultado_q;
  logic               valid_out_q;

  logic [WIDTH-1:0]   a, b;
  logic [3:0]         ctl;
  logic               is_div, is_iter, signed_op, b_zero, ovf, fast, goes_calc;
  logic               busy, issue, stall;
  logic [WIDTH-1:0]   quick_res, mag_a, mag_b;
  logic               neg_issue;

  assign a   = bus.inputA;
  assign b   = bus.inputB;
  assign ctl = bus.alu_controle;

  // Decode of the op being offered this cycle
  always_comb begin
    is_div    = ctl inside {OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    is_iter   = ctl inside {OP_MUL, OP_MULH, OP_MULHU, OP_DIV, OP_DIVU, OP_REM, OP_REMU};
    signed_op = ctl inside {OP_MULH, OP_DIV, OP_REM};
    b_zero    = (b == '0);
    ovf       = (ctl == OP_DIV || ctl == OP_REM) && (a == MOST_NEG) && (b == '1);
    fast      = is_div && (b_zero || ovf);
    goes_calc = is_iter && !fast;
    mag_a     = (signed_op && a[WIDTH-1]) ? -a : a;
    mag_b     = (signed_op && b[WIDTH-1]) ? -b : b;
    neg_issue = (ctl == OP_REM) ? a[WIDTH-1] : (signed_op && (a[WIDTH-1] ^ b[WIDTH-1]));
  end

  always_comb begin
    quick_res = '0;
    case (ctl)
      OP_ADD:           quick_res = a + b;
      OP_SUB:           quick_res = a - b;
      OP_AND:           quick_res = a & b;
      OP_OR:            quick_res = a | b;
      OP_XOR:           quick_res = a ^ b;
      OP_SLT:           quick_res = WIDTH'($signed(a) < $signed(b));
      OP_SLTU:          quick_res = WIDTH'(a < b);
      OP_DIV, OP_DIVU:  quick_res = b_zero ? '1 : MOST_NEG;
      OP_REM, OP_REMU:  quick_res = b_zero ? a : '0;
      default:          quick_res = '0;
    endcase
  end

  // FSM: state register
  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  // FSM: next state
  always_comb begin
    state_nxt = state;
    if (bus.flush) begin
      state_nxt = IDLE;
    end else begin
      case (state)
        IDLE:    if (issue && goes_calc) state_nxt = CALC;
        CALC:    if (cnt == CNT_W'(WIDTH-1)) state_nxt = FIN;
        FIN:     state_nxt = IDLE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  // FSM: outputs
  always_comb begin
    busy  = (state != IDLE);
    issue = bus.valid_in && !bus.flush && (state == IDLE);
    stall = busy || (bus.valid_in && goes_calc && !busy);
  end

  // One shift-add (multiply) or restoring shift-subtract (divide) step.
  // acc holds {partial/remainder, multiplier/dividend-quotient}.
  logic               is_mul_q;
  logic [WIDTH:0]     mul_sum, div_trial;
  logic [2*WIDTH-1:0] acc_step, prod;
  logic [WIDTH-1:0]   div_sel, div_res, fin_res;

  always_comb begin
    is_mul_q  = op_q inside {OP_MUL, OP_MULH, OP_MULHU};
    mul_sum   = {1'b0, acc[2*WIDTH-1:WIDTH]} + (acc[0] ? {1'b0, opb} : '0);
    div_trial = {acc[2*WIDTH-1:WIDTH], acc[WIDTH-1]} - {1'b0, opb};
    if (is_mul_q)
      acc_step = {mul_sum, acc[WIDTH-1:1]};
    else if (!div_trial[WIDTH])
      acc_step = {div_trial[WIDTH-1:0], acc[WIDTH-2:0], 1'b1};
    else
      acc_step = {acc[2*WIDTH-2:0], 1'b0};

    prod    = neg_q ? -acc : acc;
    div_sel = (op_q == OP_DIV || op_q == OP_DIVU) ? acc[WIDTH-1:0] : acc[2*WIDTH-1:WIDTH];
    div_res = neg_q ? -div_sel : div_sel;
    if (op_q == OP_MUL)  fin_res = prod[WIDTH-1:0];
    else if (is_mul_q)   fin_res = prod[2*WIDTH-1:WIDTH];
    else                 fin_res = div_res;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      resultado_q <= '0;
      valid_out_q <= 1'b0;
      acc         <= '0;
      opb         <= '0;
      op_q        <= '0;
      neg_q       <= 1'b0;
      cnt         <= '0;
    end else begin
      valid_out_q <= 1'b0;
      case (state)
        IDLE: begin
          if (issue) begin
            if (goes_calc) begin
              acc   <= {{WIDTH{1'b0}}, mag_a};
              opb   <= mag_b;
              op_q  <= ctl;
              neg_q <= neg_issue;
              cnt   <= '0;
            end else begin
              resultado_q <= quick_res;
              valid_out_q <= 1'b1;
            end
          end
        end
        CALC: begin
          if (!bus.flush) begin
            acc <= acc_step;
            cnt <= cnt + CNT_W'(1);
          end
        end
        FIN: begin
          if (!bus.flush) begin
            resultado_q <= fin_res;
            valid_out_q <= 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.resultado = resultado_q;
  assign bus.valid_out = valid_out_q;
  assign bus.busy      = busy;
  assign bus.stall     = stall;
  assign bus.zero      = (a == b);

endmodule

// File: tb/tb_alu_multiciclo.sv
// Scoreboard bench for alu_multiciclo: issues directed ops, a negedge monitor
// compares every valid_out against the queued value and completion cycle.
module tb_alu_multiciclo;
  localparam int W = 32;

  logic clk = 1'b0;
  logic reset = 1'b1;

  alu_multiciclo_if #(.WIDTH(W)) bus();
  alu_multiciclo #(.WIDTH(W)) dut (.clk(clk), .reset(reset), .bus(bus));

  always #5 clk = ~clk;

  typedef struct {
    string        name;
    logic [W-1:0] val;
    int           cyc;
  } exp_t;

  exp_t         sb[$];
  int           cyc = 0;
  int           checks = 0;
  int           errors = 0;
  int           busy_cnt = 0;
  int           stall_cnt = 0;
  int           t_issue = 0;
  logic [W-1:0] last_res = '0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (bus.busy)  busy_cnt++;
    if (bus.stall) stall_cnt++;
  end

  function automatic void chk(input string nm, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h expected=%h", nm, got, exp);
    end
  endfunction

  // Monitor: pops one expectation per valid_out pulse
  always @(negedge clk) begin
    if (bus.valid_out) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_valid_out got=%h expected=none (cycle %0d)", bus.resultado, cyc);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk(e.name, bus.resultado, e.val);
        chk({e.name, "_cycle"}, W'(cyc), W'(e.cyc));
      end
    end
  end

  // lat==0: no completion expected (op squashed later)
  task automatic issue(input string nm, input logic [3:0] op, input logic [W-1:0] a,
                       input logic [W-1:0] b, input logic [W-1:0] exp, input int lat,
                       input logic exp_stall);
    bus.valid_in     = 1'b1;
    bus.alu_controle = op;
    bus.inputA       = a;
    bus.inputB       = b;
    t_issue          = cyc;
    #1;
    chk({nm, "_stall"}, W'(bus.stall), W'(exp_stall));
    if (lat > 0) begin
      sb.push_back('{name: nm, val: exp, cyc: cyc + lat});
      last_res = exp;
    end
    @(posedge clk);
    #1;
    bus.valid_in = 1'b0;
  endtask

  task automatic drain();
    int i;
    i = 0;
    do begin
      @(posedge clk);
      i++;
    end while (sb.size() != 0 && i < 80);
    #1;
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL drain_timeout pending=%0d expected=0", sb.size());
      sb.delete();
    end
  endtask

  task automatic wait_until(input int target);
    for (int i = 0; i < 100 && cyc < target; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog got=timeout expected=finish");
    $fatal(1);
  end

  initial begin
    bus.valid_in     = 1'b0;
    bus.flush        = 1'b0;
    bus.alu_controle = 4'd0;
    bus.inputA       = 32'd5;
    bus.inputB       = 32'd5;
    reset            = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    chk("zero_eq_in_reset", W'(bus.zero), 32'd1);
    chk("reset_resultado", bus.resultado, 32'd0);
    chk("reset_valid_out", W'(bus.valid_out), 32'd0);
    chk("reset_busy", W'(bus.busy), 32'd0);
    reset = 1'b0;
    bus.inputB = 32'd6;
    #1;
    chk("zero_ne", W'(bus.zero), 32'd0);
    @(posedge clk);
    #1;

    // Single-cycle ops
    stall_cnt = 0;
    busy_cnt  = 0;
    issue("add", 4'd0, 32'h00000005, 32'hFFFFFFFE, 32'h00000003, 1, 1'b0);
    drain();
    chk("add_stall_cycles", W'(stall_cnt), 32'd0);

    issue("slt",  4'd5, 32'hFFFFFFFF, 32'h00000001, 32'h00000001, 1, 1'b0);
    issue("sltu", 4'd6, 32'hFFFFFFFF, 32'h00000001, 32'h00000000, 1, 1'b0);
    issue("xor",  4'd4, 32'hF0F0F0F0, 32'hFFFF0000, 32'h0F0FF0F0, 1, 1'b0);
    issue("and",  4'd2, 32'hF0F0F0F0, 32'hFFFF0000, 32'hF0F00000, 1, 1'b0);
    issue("or",   4'd3, 32'hF0F0F0F0, 32'hFFFF0000, 32'hFFFFF0F0, 1, 1'b0);
    issue("sub",  4'd1, 32'h00000003, 32'h00000005, 32'hFFFFFFFE, 1, 1'b0);
    issue("rsvd", 4'd14, 32'h12345678, 32'h1, 32'h00000000, 1, 1'b0);
    drain();
    chk("basic_busy_cycles", W'(busy_cnt), 32'd0);

    // Iterative multiply
    busy_cnt = 0;
    issue("mul", 4'd7, 32'h00000007, 32'hFFFFFFFD, 32'hFFFFFFEB, W + 2, 1'b1);
    drain();
    chk("mul_busy_cycles", W'(busy_cnt), 32'd33);
    issue("mulh",  4'd8, 32'h80000000, 32'h80000000, 32'h40000000, W + 2, 1'b1);
    drain();
    issue("mulhu", 4'd9, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, W + 2, 1'b1);
    drain();

    // Iterative divide
    issue("div",  4'd10, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD, W + 2, 1'b1);
    drain();
    issue("rem",  4'd12, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF, W + 2, 1'b1);
    drain();
    issue("divu", 4'd11, 32'd100, 32'd7, 32'd14, W + 2, 1'b1);
    drain();
    issue("remu", 4'd13, 32'd100, 32'd7, 32'd2, W + 2, 1'b1);
    drain();

    // Divide fast paths
    busy_cnt = 0;
    issue("div_ovf",   4'd10, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1, 1'b0);
    issue("rem_ovf",   4'd12, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 1, 1'b0);
    issue("divu_by0",  4'd11, 32'd5, 32'd0, 32'hFFFFFFFF, 1, 1'b0);
    issue("remu_by0",  4'd13, 32'd5, 32'd0, 32'h00000005, 1, 1'b0);
    drain();
    chk("fast_busy_cycles", W'(busy_cnt), 32'd0);

    // Flush of an in-flight divide at T+10
    issue("div_flushed", 4'd11, 32'd100, 32'd7, 32'd0, 0, 1'b1);
    wait_until(t_issue + 10);
    bus.flush = 1'b1;
    @(posedge clk);
    #1;
    bus.flush = 1'b0;
    chk("flush_busy", W'(bus.busy), 32'd0);
    chk("flush_cycle", W'(cyc), W'(t_issue + 11));
    repeat (40) @(posedge clk);
    #1;
    chk("flush_keeps_result", bus.resultado, last_res);

    // Issue with flush in the same cycle is dropped
    bus.flush = 1'b1;
    issue("add_dropped", 4'd0, 32'd1, 32'd2, 32'd0, 0, 1'b0);
    bus.flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("drop_busy", W'(bus.busy), 32'd0);

    issue("add_after_flush", 4'd0, 32'd10, 32'd20, 32'd30, 1, 1'b0);
    drain();

    // Reset in the middle of a multiply
    issue("mul_reset", 4'd7, 32'd3, 32'd5, 32'd0, 0, 1'b1);
    wait_until(t_issue + 20);
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    chk("midreset_resultado", bus.resultado, 32'd0);
    chk("midreset_busy", W'(bus.busy), 32'd0);
    chk("midreset_valid_out", W'(bus.valid_out), 32'd0);
    repeat (40) @(posedge clk);
    #1;

    issue("add_final", 4'd0, 32'd1, 32'd1, 32'd2, 1, 1'b0);
    drain();
    chk("scoreboard_empty", W'(sb.size()), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_multiciclo.md
Name: alu_multiciclo

Overview:
- Parametrised execute-stage ALU for the RV32 pipeline. It extends the single-cycle integer ALU with an iterative RV32M multiply/divide unit.
- Basic ops return a registered result one cycle after issue. MUL/MULH/MULHU/DIV/DIVU/REM/REMU run a bit-serial datapath for WIDTH cycles.
- A stall output freezes the upstream pipeline while the unit is busy.
- Combinational `zero` (operand equality) is kept for the branch comparator.

Parameters:
- WIDTH, 32, operand/result width in bits; must be ≥ 4 and even.
- CNT_W, $clog2(WIDTH)+1, iteration counter width.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high
- valid_in  in  1  issue strobe; operands and op sampled when valid_in & !busy
- flush  in  1  abort in-flight op (pipeline squash)
- inputA  in  WIDTH  operand A (rs1)
- inputB  in  WIDTH  operand B (rs2)
- alu_controle  in  4  operation select
- resultado  out  WIDTH  registered result
- valid_out  out  1  one-cycle pulse: resultado valid
- busy  out  1  iterative op in progress
- stall  out  1  busy | (valid_in & iterative op & !busy)
- zero  out  1  combinational, inputA == inputB

Behaviour:
- Op encoding:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLT (signed), 6 SLTU.
  - 7 MUL, 8 MULH (signed×signed), 9 MULHU.
  - 10 DIV, 11 DIVU, 12 REM, 13 REMU.
  - 14–15 reserved: result 0, latency 1.
- Reset (clk edge with reset=1): state IDLE; resultado=0; valid_out=0; busy=0; counter=0; internal registers cleared. Reset mid-operation discards the op and produces no valid_out.
- Arithmetic is modulo 2^WIDTH. SLT/SLTU produce 1 or 0, zero-extended.
- FSM states: IDLE, CALC, FIN.
- IDLE, issue at cycle T:
  - Basic or reserved op: resultado and valid_out=1 in T+1; stay IDLE.
  - DIV/DIVU/REM/REMU with inputB==0 (fast path): quotient = all-ones, remainder = inputA; latency 1.
  - DIV/REM with inputA = most-negative and inputB = all-ones (fast path): quotient = most-negative, remainder = 0; latency 1.
  - Any other iterative op: latch magnitudes and sign flags, counter=0, go to CALC. busy=1 from T+1.
- CALC:
  - Multiply: one shift-add step per cycle into a 2·WIDTH accumulator.
  - Divide: one restoring shift-subtract step per cycle.
  - After WIDTH steps (T+1 … T+WIDTH) go to FIN.
- FIN (cycle T+WIDTH+1):
  - Apply sign correction. Quotient is negated if the operand signs differ. Remainder takes the sign of the dividend.
  - Select the result: low half for MUL, high half for MULH/MULHU.
  - Write resultado; valid_out=1 at T+WIDTH+2; busy=0 at T+WIDTH+2; return to IDLE.
- Total latency for iterative ops: WIDTH+2 cycles. busy is high for WIDTH+1 cycles.
- valid_in while busy is ignored; upstream must hold the instruction because stall is high.
- stall is combinational and is already high in the issue cycle of an iterative op.
- flush:
  - Any state: FSM goes to IDLE, busy=0, and no valid_out is produced for the in-flight op. flush has priority over completion in FIN.
  - valid_in with flush in the same cycle: the issue is dropped.
  - resultado keeps its last value after flush.
- valid_out is a single-cycle pulse; resultado holds until the next completion.
- zero depends only on the current inputs and is independent of state and reset.

Test Plan:
- Reset, then ADD 0x00000005+0xFFFFFFFE issued at T → resultado=0x00000003 and valid_out=1 at T+1; stall never high.
- SLT 0xFFFFFFFF,0x1 → 1; SLTU same operands → 0; XOR 0xF0F0F0F0,0xFFFF0000 → 0x0F0FF0F0. Each completes back-to-back, one result per cycle.
- MUL 7×0xFFFFFFFD at T → stall=1 at T, busy T+1..T+33, valid_out at T+34 with 0xFFFFFFEB. MULH 0x80000000×0x80000000 → 0x40000000. MULHU 0xFFFFFFFF×0xFFFFFFFF → 0xFFFFFFFE.
- DIV 0xFFFFFFF9/2 → 0xFFFFFFFD; REM same operands → 0xFFFFFFFF; DIVU 100/7 → 14; REMU 100/7 → 2; each valid at T+34.
- Corner cases, each latency 1 with busy never high:
  - DIVU 5/0 → 0xFFFFFFFF.
  - REMU 5/0 → 5.
  - DIV 0x80000000/0xFFFFFFFF → 0x80000000.
  - REM of the same operands → 0.
- DIV issued, flush at T+10 → busy=0 at T+11, no valid_out. Also: a separate reset asserted at T+20 of a MUL → resultado=0, no valid_out. Also: the next ADD issued after flush completes normally.
